// File: rtl/aes_pkg.sv
// Shared AES definitions: word/block widths, round count,
// GF(2^8) doubling and the key-schedule FSM states.
package aes_pkg;

  localparam int AES_WORD_BITS  = 32;
  localparam int AES_BLOCK_BITS = 128;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^
           (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box cell, one byte in, one byte out.
// Table row n holds the outputs for inputs 16n..16n+15.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [0:255][7:0] LUT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = LUT[a];

endmodule

// File: rtl/key_word_xform.sv
// Combinational t-term of the key schedule from w[i-1],
// rcon and the i mod Nk phase; shares one 4-byte S-box row.
module key_word_xform
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic [AES_WORD_BITS-1:0] prev,
  input  logic [7:0]               rcon,
  input  logic [2:0]               ph,
  output logic [AES_WORD_BITS-1:0] t
);

  logic                     rot_ph;
  logic                     sub_ph;
  logic [AES_WORD_BITS-1:0] sin;
  logic [AES_WORD_BITS-1:0] sout;

  assign rot_ph = (ph == 3'd0);
  assign sub_ph = (NK == 8) && (ph == 3'd4);

  // one S-box row serves both the rotated and plain SubWord
  assign sin = rot_ph ? {prev[23:0], prev[31:24]}
                      : prev;

  for (genvar b = 0; b < 4; b++) begin : g_sb
    aes_sbox u_sb (
      .a(sin[8*b +: 8]),
      .y(sout[8*b +: 8])
    );
  end

  always_comb begin
    t = prev;
    unique case (1'b1)
      rot_ph:  t = sout ^ {rcon, 24'h0};
      sub_ph:  t = sout;
      default: t = prev;
    endcase
  end

endmodule

// File: rtl/key_schedule_engine.sv
// Iterative AES key expansion, one schedule word per cycle.
// Optional KEYEXP_FINAL_KEY_EN exposes the last Nk words.
module key_schedule_engine
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [KEY_BITS-1:0]       key_in,
  output logic                      busy,
  output logic                      rk_valid,
  input  logic                      rk_ready,
  output logic [AES_BLOCK_BITS-1:0] rk_data,
  output logic [3:0]                rk_index,
  output logic                      done
`ifdef KEYEXP_FINAL_KEY_EN
  ,
  output logic [KEY_BITS-1:0]       final_key,
  output logic                      final_key_valid
`endif
);

  localparam int NK = KEY_BITS / AES_WORD_BITS;
  localparam int NR = nr_of(NK);
  localparam int NW = 4 * (NR + 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 &&
      KEY_BITS != 256) begin : g_bad_key
    $error("KEY_BITS must be 128, 192 or 256");
  end

  state_t state;
  state_t state_nx;

  logic [0:NK-1][AES_WORD_BITS-1:0] win;
  logic [0:2][AES_WORD_BITS-1:0]    acc;
  logic [AES_WORD_BITS-1:0]         t;
  logic [AES_WORD_BITS-1:0]         nw;
  logic [5:0]                       i;
  logic [2:0]                       ph;
  logic [1:0]                       acc_n;
  logic [7:0]                       rcon;
  logic                             acc_start;
  logic                             stall;
  logic                             gen;
  logic                             last;
  logic                             load;
  logic                             hs;

  assign acc_start = (state == IDLE) & start;
  assign hs    = rk_valid & rk_ready;
  assign stall = (acc_n == 2'd3) & rk_valid &
                 ~rk_ready;
  assign gen   = (state == RUN) & ~stall;
  assign last  = (i == 6'(NW - 1));
  assign load  = gen & (acc_n == 2'd3);
  assign busy  = (state != IDLE);

  // win[0] is w[i-Nk], win[NK-1] is w[i-1]
  assign nw = (i < 6'(NK)) ? win[0] : win[0] ^ t;

  key_word_xform #(
    .NK(NK)
  ) u_xform (
    .prev(win[NK-1]),
    .rcon(rcon),
    .ph  (ph),
    .t   (t)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)       state_nx = RUN;
      RUN:     if (gen && last) state_nx = DRAIN;
      DRAIN:   if (hs)          state_nx = IDLE;
      default:                  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win      <= '0;
      acc      <= '0;
      i        <= '0;
      ph       <= '0;
      acc_n    <= '0;
      rcon     <= 8'h01;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_index <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == DRAIN) & hs;
      if (acc_start) begin
        win   <= key_in;
        i     <= '0;
        ph    <= '0;
        acc_n <= '0;
        rcon  <= 8'h01;
      end else if (gen) begin
        // key words recirculate so win is w0..w(Nk-1) at i=Nk
        for (int j = 0; j < NK - 1; j++)
          win[j] <= win[j+1];
        win[NK-1] <= nw;
        i  <= i + 6'd1;
        ph <= (ph == 3'(NK - 1)) ? 3'd0
                                 : ph + 3'd1;
        if (i >= 6'(NK) && ph == 3'd0)
          rcon <= xtime(rcon);
        acc   <= {acc[1], acc[2], nw};
        acc_n <= acc_n + 2'd1;
      end
      if (load) begin
        rk_data  <= {acc, nw};
        rk_index <= i[5:2];
      end
      if (load)    rk_valid <= 1'b1;
      else if (hs) rk_valid <= 1'b0;
    end
  end

`ifdef KEYEXP_FINAL_KEY_EN
  assign final_key = win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      final_key_valid <= 1'b0;
    else if (acc_start)
      final_key_valid <= 1'b0;
    else if (state == DRAIN && hs)
      final_key_valid <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_key_schedule_engine.sv
// Directed bench for key_schedule_engine at 128/192/256 bits,
// including backpressure, abort and KEYEXP_FINAL_KEY_EN.
module tb_key_schedule_engine;

  localparam logic [127:0] K128 =
    128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 =
    192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [127:0] EXP128 [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic clk;
  logic rst;
  logic rdy;
  logic start128, start192, start256;
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;
  logic b128, b192, b256;
  logic v128, v192, v256;
  logic dn128, dn192, dn256;
  logic [127:0] d128, d192, d256;
  logic [3:0] i128, i192, i256;
`ifdef KEYEXP_FINAL_KEY_EN
  logic [127:0] fk128;
  logic [191:0] fk192;
  logic [255:0] fk256;
  logic fkv128, fkv192, fkv256;
  logic fkv_done;
`endif

  int tests;
  int fails;
  int sel;
  logic m_valid, m_done, m_busy;
  logic [127:0] m_data;
  logic [3:0] m_index;

  logic [127:0] got [0:15];
  int gidx [0:15];
  int gcyc [0:15];
  int got_n;
  int done_cyc;

  key_schedule_engine #(.KEY_BITS(128)) u128 (
    .clk(clk), .rst(rst), .start(start128),
    .key_in(key128), .busy(b128),
    .rk_valid(v128), .rk_ready(rdy),
    .rk_data(d128), .rk_index(i128),
    .done(dn128)
`ifdef KEYEXP_FINAL_KEY_EN
    , .final_key(fk128), .final_key_valid(fkv128)
`endif
  );

  key_schedule_engine #(.KEY_BITS(192)) u192 (
    .clk(clk), .rst(rst), .start(start192),
    .key_in(key192), .busy(b192),
    .rk_valid(v192), .rk_ready(rdy),
    .rk_data(d192), .rk_index(i192),
    .done(dn192)
`ifdef KEYEXP_FINAL_KEY_EN
    , .final_key(fk192), .final_key_valid(fkv192)
`endif
  );

  key_schedule_engine #(.KEY_BITS(256)) u256 (
    .clk(clk), .rst(rst), .start(start256),
    .key_in(key256), .busy(b256),
    .rk_valid(v256), .rk_ready(rdy),
    .rk_data(d256), .rk_index(i256),
    .done(dn256)
`ifdef KEYEXP_FINAL_KEY_EN
    , .final_key(fk256), .final_key_valid(fkv256)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    m_valid = v128;
    m_data  = d128;
    m_index = i128;
    m_done  = dn128;
    m_busy  = b128;
    if (sel == 1) begin
      m_valid = v192;
      m_data  = d192;
      m_index = i192;
      m_done  = dn192;
      m_busy  = b192;
    end else if (sel == 2) begin
      m_valid = v256;
      m_data  = d256;
      m_index = i256;
      m_done  = dn256;
      m_busy  = b256;
    end
  end

  // cycle c counts negedges after the start cycle (cycle 0)
  task automatic capture(input int duty,
                         input int pulse_at);
    logic hold;
    logic [127:0] hd;
    logic [3:0] hi;
    hold = 1'b0;
    hd = '0;
    hi = '0;
    got_n = 0;
    done_cyc = -1;
    for (int c = 1; c < 400 && done_cyc < 0; c++) begin
      @(negedge clk);
      start128 = 1'b0;
      start192 = 1'b0;
      start256 = 1'b0;
      if (hold) begin
        tests++;
        if (m_valid !== 1'b1 || m_data !== hd ||
            m_index !== hi) begin
          fails++;
          $display("FAIL stall_hold c=%0d v=%b d=%h i=%0d want v=1 d=%h i=%0d",
                   c, m_valid, m_data, m_index, hd, hi);
        end
      end
      if (c == pulse_at) begin
        tests++;
        if (m_busy !== 1'b1) begin
          fails++;
          $display("FAIL busy_at_pulse got %b want 1",
                   m_busy);
        end
        start128 = 1'b1;
        key128 = ~key128;
      end
      if (m_done === 1'b1) begin
        done_cyc = c;
`ifdef KEYEXP_FINAL_KEY_EN
        fkv_done = fkv128;
`endif
      end
      rdy = (int'($urandom_range(99, 0)) < duty);
      if (m_valid === 1'b1 && rdy) begin
        if (got_n < 16) begin
          got[got_n]  = m_data;
          gidx[got_n] = int'(m_index);
          gcyc[got_n] = c;
        end
        got_n++;
      end
      hold = (m_valid === 1'b1) && !rdy;
      hd = m_data;
      hi = m_index;
    end
    if (done_cyc < 0) begin
      tests++;
      fails++;
      $display("FAIL capture_timeout got %0d keys, no done",
               got_n);
    end
  endtask

  task automatic check_seq128(input string nm);
    tests++;
    if (got_n != 11) begin
      fails++;
      $display("FAIL %s_count got %0d want 11", nm, got_n);
    end
    for (int k = 0; k < 11 && k < got_n; k++) begin
      tests++;
      if (got[k] !== EXP128[k] || gidx[k] != k) begin
        fails++;
        $display("FAIL %s_r%0d got %h idx %0d want %h idx %0d",
                 nm, k, got[k], gidx[k], EXP128[k], k);
      end
    end
  endtask

  task automatic test_reset();
    rdy = 1'b1;
    start128 = 1'b0;
    start192 = 1'b0;
    start256 = 1'b0;
    key128 = '0;
    key192 = '0;
    key256 = '0;
    sel = 0;
    rst = 1'b0;
    #3 rst = 1'b1;
    #1;
    tests++;
    if ({b128, v128, dn128, d128, i128} !== '0 ||
        {b192, v192, dn192, d192, i192} !== '0 ||
        {b256, v256, dn256, d256, i256} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got %b%b%b %h %0d want all 0",
               b128, v128, dn128, d128, i128);
    end
`ifdef KEYEXP_FINAL_KEY_EN
    tests++;
    if ({fkv128, fkv192, fkv256} !== 3'b000 ||
        fk128 !== '0 || fk192 !== '0 ||
        fk256 !== '0) begin
      fails++;
      $display("FAIL reset_final_key got %b%b%b want 000",
               fkv128, fkv192, fkv256);
    end
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (v128 !== 1'b0 || b128 !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset got v=%b b=%b want 0 0",
               v128, b128);
    end
  endtask

  task automatic test_aes128();
    sel = 0;
    @(negedge clk);
    key128 = K128;
    start128 = 1'b1;
    capture(100, 0);
    check_seq128("aes128");
    tests++;
    if (gcyc[0] != 5 || gcyc[10] != 45) begin
      fails++;
      $display("FAIL aes128_latency got r0@%0d r10@%0d want 5 45",
               gcyc[0], gcyc[10]);
    end
    tests++;
    if (done_cyc != 46) begin
      fails++;
      $display("FAIL aes128_done_cycle got %0d want 46",
               done_cyc);
    end
  endtask

  task automatic test_aes192();
    sel = 1;
    @(negedge clk);
    key192 = K192;
    start192 = 1'b1;
    capture(100, 0);
    tests++;
    if (got_n != 13 || done_cyc != 54) begin
      fails++;
      $display("FAIL aes192_count got %0d done@%0d want 13 54",
               got_n, done_cyc);
    end
    tests++;
    if (got[0] !== K192[191:64]) begin
      fails++;
      $display("FAIL aes192_r0 got %h want %h",
               got[0], K192[191:64]);
    end
    tests++;
    if (got[1] !== 128'h62f8ead2522c6b7bfe0c91f72402f5a5) begin
      fails++;
      $display("FAIL aes192_r1 got %h want 62f8ead2522c6b7bfe0c91f72402f5a5",
               got[1]);
    end
    tests++;
    if (got[12][31:0] !== 32'h01002202 || gidx[12] != 12) begin
      fails++;
      $display("FAIL aes192_w51 got %h idx %0d want 01002202 idx 12",
               got[12][31:0], gidx[12]);
    end
  endtask

  task automatic test_aes256();
    sel = 2;
    @(negedge clk);
    key256 = K256;
    start256 = 1'b1;
    capture(100, 0);
    tests++;
    if (got_n != 15 || done_cyc != 62) begin
      fails++;
      $display("FAIL aes256_count got %0d done@%0d want 15 62",
               got_n, done_cyc);
    end
    tests++;
    if (got[0] !== K256[255:128] ||
        got[1] !== K256[127:0]) begin
      fails++;
      $display("FAIL aes256_r0r1 got %h %h want key halves",
               got[0], got[1]);
    end
    tests++;
    if (got[2][127:96] !== 32'h9ba35411) begin
      fails++;
      $display("FAIL aes256_w8 got %h want 9ba35411",
               got[2][127:96]);
    end
    tests++;
    if (got[14] !== 128'hfe4890d1e6188d0b046df344706c631e ||
        gidx[14] != 14) begin
      fails++;
      $display("FAIL aes256_r14 got %h idx %0d want fe4890d1e6188d0b046df344706c631e idx 14",
               got[14], gidx[14]);
    end
  endtask

  task automatic test_backpressure();
    sel = 0;
    @(negedge clk);
    key128 = K128;
    start128 = 1'b1;
    capture(30, 0);
    check_seq128("bp");
  endtask

  task automatic test_busy_start();
    sel = 0;
    @(negedge clk);
    key128 = K128;
    start128 = 1'b1;
    capture(100, 12);
    check_seq128("busy_start");
    tests++;
    if (done_cyc != 46) begin
      fails++;
      $display("FAIL busy_start_done got %0d want 46",
               done_cyc);
    end
  endtask

  task automatic test_abort();
    logic found;
    int leaks;
    sel = 0;
    found = 1'b0;
    leaks = 0;
    @(negedge clk);
    key128 = K128;
    start128 = 1'b1;
    for (int c = 1; c < 40 && !found; c++) begin
      @(negedge clk);
      start128 = 1'b0;
      rdy = 1'b1;
      if (m_valid === 1'b1 && m_index === 4'd3)
        found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL abort_r3_seen got none want r3 within 40");
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({m_busy, m_valid, m_done} !== 3'b000 ||
        m_data !== '0 || m_index !== 4'd0) begin
      fails++;
      $display("FAIL abort_outputs got %b%b%b %h %0d want all 0",
               m_busy, m_valid, m_done, m_data, m_index);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (m_valid !== 1'b0 || m_busy !== 1'b0) leaks++;
    end
    tests++;
    if (leaks != 0) begin
      fails++;
      $display("FAIL abort_quiet got %0d active cycles want 0",
               leaks);
    end
    key128 = K128;
    start128 = 1'b1;
    capture(100, 0);
    tests++;
    if (got_n < 1 || gcyc[0] != 5 || got[0] !== K128) begin
      fails++;
      $display("FAIL abort_restart got n=%0d r0@%0d %h want r0@5 %h",
               got_n, gcyc[0], got[0], K128);
    end
    check_seq128("restart");
  endtask

`ifdef KEYEXP_FINAL_KEY_EN
  task automatic test_final_key();
    sel = 0;
    fkv_done = 1'b0;
    @(negedge clk);
    key128 = K128;
    start128 = 1'b1;
    capture(100, 0);
    tests++;
    if (fkv_done !== 1'b1) begin
      fails++;
      $display("FAIL fk_valid_with_done got %b want 1",
               fkv_done);
    end
    tests++;
    if (fk128 !== EXP128[10]) begin
      fails++;
      $display("FAIL final_key got %h want %h",
               fk128, EXP128[10]);
    end
    @(negedge clk);
    start128 = 1'b1;
    @(negedge clk);
    start128 = 1'b0;
    tests++;
    if (fkv128 !== 1'b0) begin
      fails++;
      $display("FAIL fk_valid_clear got %b want 0", fkv128);
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    got_n = 0;
    done_cyc = -1;
    for (int k = 0; k < 16; k++) begin
      got[k] = '0;
      gidx[k] = -1;
      gcyc[k] = -1;
    end
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_backpressure();
    test_busy_start();
    test_abort();
`ifdef KEYEXP_FINAL_KEY_EN
    test_final_key();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
